// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses 0xA5-framed UART commands into sine/PWM generator config registers and returns one ACK/NAK/status byte per frame; define CMD_CHECKSUM_EN to require the trailing XOR checksum byte.
module uart_cmd_decoder #(
  parameter int          FREQ_W   = 16,
  parameter logic [15:0] FREQ_RST = 16'd64,
  parameter int          TIMEOUT  = 50000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [FREQ_W-1:0] freq_word,
  output logic [7:0]        amp,
  output logic              wave_en,
  output logic              cfg_update,
  output logic              frame_err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CMD, DATA, CSUM, RESP} state_t;
  state_t        state, state_n;
  logic [7:0]    cmd, cur_cmd, csum;
  logic [1:0]    cnt, len;
  logic [15:0]   sh, val;
  logic [TW-1:0] tmo;
  logic          known, in_frame, expire, done, nak, bad;
  always_comb begin
    cur_cmd  = (state == CMD) ? rx_data : cmd;
    known    = cur_cmd inside {[8'h01:8'h04]};
    len      = (cur_cmd == 8'h01) ? 2'd2 : (cur_cmd == 8'h04) ? 2'd0 : 2'd1;
    in_frame = state inside {CMD, DATA, CSUM};
    expire   = in_frame && !rx_valid && tmo == TW'(TIMEOUT - 1);
`ifdef CMD_CHECKSUM_EN
    val      = sh;
`else
    val      = {sh[7:0], rx_data};
`endif
    state_n  = state;
    done     = 1'b0;
    nak      = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE: if (rx_valid && rx_data == 8'hA5) state_n = CMD;
      CMD: if (rx_valid) begin
        if (!known) nak = 1'b1;
`ifdef CMD_CHECKSUM_EN
        else state_n = (len == 2'd0) ? CSUM : DATA;
`else
        else if (len == 2'd0) done = 1'b1;
        else state_n = DATA;
`endif
      end
      DATA: if (rx_valid && cnt == 2'd1) begin
`ifdef CMD_CHECKSUM_EN
        state_n = CSUM;
`else
        done = 1'b1;
`endif
      end
      CSUM: if (rx_valid) begin
        done = (csum == rx_data);
        nak  = (csum != rx_data);
        bad  = (csum != rx_data);
      end
      RESP: if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (done || nak) state_n = RESP;
    if (expire) state_n = IDLE;
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      cnt        <= '0;
      sh         <= '0;
      csum       <= '0;
      tmo        <= '0;
      freq_word  <= FREQ_RST[FREQ_W-1:0];
      amp        <= 8'hFF;
      wave_en    <= 1'b0;
      tx_data    <= '0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      tmo        <= (in_frame && !rx_valid) ? tmo + 1'b1 : '0;
      cfg_update <= done && cur_cmd != 8'h04;
      frame_err  <= bad || expire;
      if (state == CMD && rx_valid) begin
        cmd  <= rx_data;
        cnt  <= len;
        csum <= rx_data;
      end
      if (state == DATA && rx_valid) begin
        cnt  <= cnt - 2'd1;
        sh   <= {sh[7:0], rx_data};
        csum <= csum ^ rx_data;
      end
      if (done || nak) tx_data <= nak ? 8'h15 : (cur_cmd == 8'h04) ? amp : 8'h06;
      if (done && cur_cmd == 8'h01) freq_word <= val[FREQ_W-1:0];
      if (done && cur_cmd == 8'h02) amp <= val[7:0];
      if (done && cur_cmd == 8'h03) wave_en <= val[0];
    end
  end
  assign tx_valid = (state == RESP);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed scenario tasks for uart_cmd_decoder; expectations follow CMD_CHECKSUM_EN.
module tb_uart_cmd_decoder;
  logic        clk1 = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_data = '0, tx_data, amp;
  logic        tx_valid, wave_en, cfg_update, frame_err;
  logic [15:0] freq_word;
  logic [7:0]  exp_amp = 8'hFF;
  int          vectors = 0, miscompares = 0;

  uart_cmd_decoder #(.FREQ_W(16), .FREQ_RST(16'd64), .TIMEOUT(100)) dut (
    .clk1(clk1), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .freq_word(freq_word), .amp(amp), .wave_en(wave_en),
    .cfg_update(cfg_update), .frame_err(frame_err));

  always #5 clk1 = ~clk1;

  task automatic send(input logic [7:0] b);
    @(negedge clk1) begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk1) rx_valid = 1'b0;
  endtask

  task automatic handshake;
    @(negedge clk1) tx_ready = 1'b1;
    @(negedge clk1) tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    vectors++; if (freq_word !== 16'd64) begin miscompares++; $display("FAIL reset_freq got %h want 0040", freq_word); end
    vectors++; if (amp !== 8'hFF) begin miscompares++; $display("FAIL reset_amp got %h want ff", amp); end
    vectors++; if (wave_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", wave_en); end
    vectors++; if ({tx_valid, tx_data, cfg_update, frame_err} !== 11'd0) begin miscompares++; $display("FAIL reset_flags got %b_%h_%b_%b want 0", tx_valid, tx_data, cfg_update, frame_err); end
  endtask

  task automatic test_freq;
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
`ifdef CMD_CHECKSUM_EN
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL freq_early_tx got %b want 0", tx_valid); end
    send(8'h27);
`endif
    vectors++; if (freq_word !== 16'h1234) begin miscompares++; $display("FAIL freq_word got %h want 1234", freq_word); end
    vectors++; if (cfg_update !== 1'b1) begin miscompares++; $display("FAIL freq_cfg_update got %b want 1", cfg_update); end
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin miscompares++; $display("FAIL freq_ack got %b/%h want 1/06", tx_valid, tx_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      vectors++; if ({tx_valid, tx_data, cfg_update} !== {1'b1, 8'h06, 1'b0}) begin miscompares++; $display("FAIL freq_hold%0d got %b/%h/%b want 1/06/0", i, tx_valid, tx_data, cfg_update); end
    end
    handshake;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL freq_release got %b want 0", tx_valid); end
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_bad_csum;
    send(8'hA5); send(8'h02); send(8'h80); send(8'h00);
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin miscompares++; $display("FAIL csum_nak got %b/%h want 1/15", tx_valid, tx_data); end
    vectors++; if ({frame_err, cfg_update} !== 2'b10) begin miscompares++; $display("FAIL csum_flags got err=%b upd=%b want 1/0", frame_err, cfg_update); end
    vectors++; if (amp !== 8'hFF) begin miscompares++; $display("FAIL csum_amp got %h want ff", amp); end
    @(negedge clk1);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL csum_err_pulse got %b want 0", frame_err); end
    handshake;
    send(8'hA5); send(8'h01); send(8'hAB); send(8'hCD); send(8'h26);
    vectors++; if ({tx_data, freq_word} !== {8'h15, 16'h1234}) begin miscompares++; $display("FAIL csum_freq got %h/%h want 15/1234", tx_data, freq_word); end
    handshake;
  endtask
`else
  task automatic test_amp_nocsum;
    send(8'hA5); send(8'h02); send(8'h40);
    exp_amp = 8'h40;
    vectors++; if ({amp, cfg_update} !== {8'h40, 1'b1}) begin miscompares++; $display("FAIL amp_write got %h/%b want 40/1", amp, cfg_update); end
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin miscompares++; $display("FAIL amp_ack got %b/%h want 1/06", tx_valid, tx_data); end
    handshake;
  endtask
`endif

  task automatic test_timeout;
    send(8'hA5); send(8'h03);
    repeat (99) @(negedge clk1);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", frame_err); end
    @(negedge clk1);
    vectors++; if ({frame_err, tx_valid} !== 2'b10) begin miscompares++; $display("FAIL tmo_pulse got err=%b tx=%b want 1/0", frame_err, tx_valid); end
    @(negedge clk1);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_clear got %b want 0", frame_err); end
    send(8'h01);
    vectors++; if ({tx_valid, wave_en} !== 2'b00) begin miscompares++; $display("FAIL tmo_idle got tx=%b en=%b want 0/0", tx_valid, wave_en); end
    send(8'hA5); send(8'h03); send(8'h01);
`ifdef CMD_CHECKSUM_EN
    send(8'h02);
`endif
    vectors++; if ({wave_en, cfg_update, tx_valid, tx_data} !== {3'b111, 8'h06}) begin miscompares++; $display("FAIL en_write got en=%b upd=%b tx=%b/%h want 1/1/1/06", wave_en, cfg_update, tx_valid, tx_data); end
    handshake;
  endtask

  task automatic test_unknown_status;
    send(8'hA5); send(8'h09);
    vectors++; if ({tx_valid, tx_data, frame_err, cfg_update} !== {1'b1, 8'h15, 2'b00}) begin miscompares++; $display("FAIL unk_nak got %b/%h err=%b upd=%b want 1/15/0/0", tx_valid, tx_data, frame_err, cfg_update); end
    send(8'hA5); send(8'h04);
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin miscompares++; $display("FAIL resp_drop got %b/%h want 1/15", tx_valid, tx_data); end
    handshake;
    send(8'h04); send(8'h04);
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL resp_no_queue got %b want 0", tx_valid); end
    send(8'hA5); send(8'h04);
`ifdef CMD_CHECKSUM_EN
    send(8'h04);
`endif
    vectors++; if ({tx_valid, tx_data, cfg_update} !== {1'b1, exp_amp, 1'b0}) begin miscompares++; $display("FAIL status got %b/%h upd=%b want 1/%h/0", tx_valid, tx_data, cfg_update, exp_amp); end
    handshake;
  endtask

  task automatic test_reset_mid_frame;
    send(8'hA5); send(8'h01); send(8'h55);
    @(negedge clk1) rst = 1'b1;
    @(negedge clk1) rst = 1'b0;
    vectors++; if ({freq_word, amp, wave_en, tx_valid} !== {16'd64, 8'hFF, 2'b00}) begin miscompares++; $display("FAIL rst_mid got %h/%h/%b/%b want 0040/ff/0/0", freq_word, amp, wave_en, tx_valid); end
    send(8'h66); send(8'h33);
    vectors++; if ({freq_word, tx_valid} !== {16'd64, 1'b0}) begin miscompares++; $display("FAIL rst_discard got %h/%b want 0040/0", freq_word, tx_valid); end
  endtask

  initial begin
    test_reset;
    test_freq;
`ifdef CMD_CHECKSUM_EN
    test_bad_csum;
`else
    test_amp_nocsum;
`endif
    test_timeout;
    test_unknown_status;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
